// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI burst read master.
//   state_t     : FSM state encoding (IDLE, ADDR, DATA, DRAIN, DONE)
//   AXI_MAX_LEN : largest burst an AXI4 INCR request can describe
//   min_beats() : burst length for the next request
package axi_rd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned AXI_MAX_LEN = 256;

    // Beats for the next burst: whatever is left, capped at the burst limit.
    function automatic int unsigned min_beats(input int unsigned remaining,
                                              input int unsigned max_beats);
        return (remaining < max_beats) ? remaining : max_beats;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word-fall-through (dout shows the head entry).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   push, din  : write request and data; accepted when not full, or when
//                full and a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head entry, 0 while empty
//   full, empty, count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        pop,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    // A pop on a full FIFO frees the slot the simultaneous push uses.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr_q];

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/axi_burst_read_master.sv
// AXI4-style read master. Splits a word-addressed request (base_addr,
// num_words) into INCR bursts of at most MAX_BURST beats, one outstanding
// at a time, buffers returned beats and streams them out.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, base_addr, num_words: request (sampled only while idle)
//   busy, done                 : status; done is a one-cycle pulse
//   araddr, arlen, arvalid, arready : AR channel (araddr in words)
//   rdata, rvalid, rready, rlast    : R channel
//   m_data, m_valid, m_ready        : output stream (FIFO head)
//   rlast_err (only with AXI_RD_RLAST_CHECK_EN): sticky rlast mismatch flag
// Handshakes: a transfer happens on any rising clk edge where valid and
// ready are both 1; valid never depends on ready, and a raised valid
// holds its payload until that transfer.
// Build option: define AXI_RD_RLAST_CHECK_EN to add the rlast checker.
module axi_burst_read_master
    import axi_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic                  rlast,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef AXI_RD_RLAST_CHECK_EN
    ,
    output logic                  rlast_err
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic                  done_q, done_d;

    logic [8:0]            beats;
    logic                  space_ok;
    logic                  fifo_push;
    logic                  fifo_empty;
    logic                  fifo_full_unused;
    logic [CW-1:0]         fifo_count;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (rdata),
        .pop   (m_ready),
        .dout  (m_data),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign busy    = (state_q == ADDR) || (state_q == DATA) || (state_q == DRAIN);
    assign done    = done_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arvalid = arvalid_q;
    // Room for the whole burst was reserved before the AR went out.
    assign rready  = (state_q == DATA);

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        fifo_push   = 1'b0;

        beats    = 9'(min_beats(32'(remaining_q), 32'(MAX_BURST)));
        // Only pops happen while waiting here, so free space never shrinks
        // between admitting a burst and receiving its beats.
        space_ok = (32'(FIFO_DEPTH) - 32'(fifo_count)) >= 32'(beats);
        done_d   = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        cur_addr_d  = base_addr;
                        remaining_d = num_words;
                        state_d     = ADDR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ADDR: begin
                if (!arvalid_q) begin
                    if (space_ok) begin
                        arvalid_d = 1'b1;
                        araddr_d  = cur_addr_q;
                        arlen_d   = 8'(beats - 9'd1);
                    end
                end else if (arready) begin
                    arvalid_d  = 1'b0;
                    beat_cnt_d = beats;
                    state_d    = DATA;
                end
            end
            DATA: begin
                // Beat count, not rlast, decides where the burst ends.
                if (rvalid) begin
                    fifo_push  = 1'b1;
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    if (beat_cnt_q == 9'd1) begin
                        cur_addr_d  = cur_addr_q + ADDR_WIDTH'(beats);
                        remaining_d = remaining_q - CNT_WIDTH'(beats);
                        state_d     = (remaining_q == CNT_WIDTH'(beats)) ? DRAIN : ADDR;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            done_q      <= done_d;
        end
    end

`ifdef AXI_RD_RLAST_CHECK_EN
    logic rlast_err_q;

    // rlast must be high exactly on the beat that brings beat_cnt to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rlast_err_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            rlast_err_q <= 1'b0;
        end else if (state_q == DATA && rvalid && (rlast != (beat_cnt_q == 9'd1))) begin
            rlast_err_q <= 1'b1;
        end
    end

    assign rlast_err = rlast_err_q;
`else
    logic unused_rlast;
    assign unused_rlast = rlast;
`endif

endmodule

// File: tb/tb_axi_burst_read_master.sv
module tb_axi_burst_read_master;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic        busy, done;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_ready_force = 1'b1;
    logic        m_ready_rand;
    logic        mr_random = 1'b0;
`ifdef AXI_RD_RLAST_CHECK_EN
    logic        rlast_err;
`endif

    assign m_ready = mr_random ? m_ready_rand : m_ready_force;

    axi_burst_read_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .araddr    (araddr),
        .arlen     (arlen),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .rlast     (rlast),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
`ifdef AXI_RD_RLAST_CHECK_EN
        ,
        .rlast_err (rlast_err)
`endif
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];      // expected stream words, in order
    logic [39:0] exp_ar[$];     // expected {araddr, arlen}
    int ar_count = 0;
    int done_count = 0;
    int r_beats = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: word at address a is a+1; a transfer is cut into
    // bursts of min(remaining, 16) words at consecutive (wrapping) addresses.
    task automatic model_xfer(input logic [31:0] base, input int n);
        logic [31:0] a;
        int rem, b;
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i) + 32'd1);
        a = base;
        rem = n;
        while (rem > 0) begin
            b = (rem < 16) ? rem : 16;
            exp_ar.push_back({a, 8'(b - 1)});
            a = a + 32'(b);
            rem = rem - b;
        end
    endtask

    // ---------------- slave model + monitor ----------------
    logic [31:0] s_addr = '0;
    int          s_left = 0;
    logic        ar_fire, r_fire;
    logic [31:0] ar_a;
    logic [7:0]  ar_l;
    logic [31:0] exp_w;

    initial begin
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        rdata = '0;
        m_ready_rand = 1'b0;
        forever begin
            @(negedge clk);
            ar_fire = rst_n && arvalid && arready;
            r_fire  = rst_n && rvalid && rready;
            ar_a = araddr;
            ar_l = arlen;
            if (rst_n) begin
                if (ar_fire) begin
                    ar_count++;
                    chk("ar_outstanding", 64'(exp_ar.size() > 0), 64'd1);
                    if (exp_ar.size() > 0) chk("ar_addr_len", {24'd0, araddr, arlen}, {24'd0, exp_ar.pop_front()});
                end
                if (r_fire) r_beats++;
                if (m_valid && m_ready) begin
                    chk("pop_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        exp_w = exp_q.pop_front();
                        chk("m_data", 64'(m_data), 64'(exp_w));
                    end
                end
                if (done) begin
                    done_count++;
                    chk("busy_at_done", 64'(busy), 64'd0);
                end
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_left = 0;
                arready = 1'b0;
                rvalid = 1'b0;
                rlast = 1'b0;
            end else begin
                if (ar_fire) begin
                    s_addr = ar_a;
                    s_left = int'(ar_l) + 1;
                end
                if (r_fire) begin
                    s_addr = s_addr + 32'd1;
                    s_left = s_left - 1;
                end
                if (!(rvalid && !r_fire)) rvalid = (s_left > 0) && ($urandom_range(0, 3) != 0);
                rdata = s_addr + 32'd1;
                rlast = (s_left == 1);
                arready = (s_left == 0) && ($urandom_range(0, 1) == 1);
            end
            m_ready_rand = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_xfer(input logic [31:0] base, input int n);
        model_xfer(base, n);
        base_addr = base;
        num_words = 16'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(n != 0));
        chk("arvalid_lat1", 64'(arvalid), 64'd0);
        step();
        if (n != 0) chk("arvalid_lat2", 64'(arvalid), 64'd1);
    endtask

    task automatic finish_xfer(input int d0, input string tag);
        int t;
        t = 0;
        while (done_count == d0 && t < 4000) begin
            step();
            t++;
        end
        chk({tag, "_done_timeout"}, 64'(done_count > d0), 64'd1);
        step();
        step();
        chk({tag, "_one_done"}, 64'(done_count - d0), 64'd1);
        chk({tag, "_all_words"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_all_ars"}, 64'(exp_ar.size()), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_mvalid"}, 64'(m_valid), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0, a0, r0, t;
        logic [31:0] rb;
        int rn;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_mdata", 64'(m_data), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // single full burst
        d0 = done_count; a0 = ar_count;
        start_xfer(32'd0, 16);
        finish_xfer(d0, "t1");
        chk("t1_ar_count", 64'(ar_count - a0), 64'd1);

        // three bursts, last one short
        d0 = done_count; a0 = ar_count;
        start_xfer(32'd8, 40);
        finish_xfer(d0, "t2");
        chk("t2_ar_count", 64'(ar_count - a0), 64'd3);

        // back-pressure: FIFO fills, third AR withheld
        m_ready_force = 1'b0;
        d0 = done_count; a0 = ar_count; r0 = r_beats;
        start_xfer(32'd8, 40);
        t = 0;
        while (r_beats - r0 < 32 && t < 2000) begin
            step();
            t++;
        end
        chk("t3_fill_timeout", 64'(r_beats - r0), 64'd32);
        repeat (20) step();
        chk("t3_two_ars", 64'(ar_count - a0), 64'd2);
        chk("t3_ar_withheld", 64'(arvalid), 64'd0);
        chk("t3_no_more_beats", 64'(r_beats - r0), 64'd32);
        chk("t3_mvalid", 64'(m_valid), 64'd1);
        m_ready_force = 1'b1;
        finish_xfer(d0, "t3");
        chk("t3_ar_count", 64'(ar_count - a0), 64'd3);

        // zero-length request
        d0 = done_count; a0 = ar_count;
        base_addr = 32'd55;
        num_words = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_busy1", 64'(busy), 64'd0);
        chk("t4_done1", 64'(done), 64'd0);
        step();
        chk("t4_done2", 64'(done), 64'd1);
        chk("t4_busy2", 64'(busy), 64'd0);
        step();
        chk("t4_done3", 64'(done), 64'd0);
        repeat (3) step();
        chk("t4_no_ar", 64'(ar_count - a0), 64'd0);
        chk("t4_one_done", 64'(done_count - d0), 64'd1);

        // start while busy is ignored
        d0 = done_count; a0 = ar_count;
        start_xfer(32'd8, 40);
        repeat (10) step();
        base_addr = 32'd500;
        num_words = 16'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        finish_xfer(d0, "t5");
        chk("t5_ar_count", 64'(ar_count - a0), 64'd3);

        // address wrap at the top of the address space
        d0 = done_count;
        start_xfer(32'hFFFF_FFF8, 20);
        finish_xfer(d0, "t6");

        // randomized transfers with random stream back-pressure
        mr_random = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rb = $urandom;
            rn = $urandom_range(1, 60);
            d0 = done_count;
            start_xfer(rb, rn);
            finish_xfer(d0, "rnd");
        end
        mr_random = 1'b0;

        // reset in the middle of the second burst
        a0 = ar_count;
        start_xfer(32'd8, 40);
        t = 0;
        while (ar_count - a0 < 2 && t < 1000) begin
            step();
            t++;
        end
        chk("t7_second_ar", 64'(ar_count - a0), 64'd2);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_arvalid", 64'(arvalid), 64'd0);
        chk("t7_rready", 64'(rready), 64'd0);
        chk("t7_mvalid", 64'(m_valid), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        exp_q.delete();
        exp_ar.delete();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("t7_post_busy", 64'(busy), 64'd0);
        d0 = done_count;
        start_xfer(32'd100, 4);
        finish_xfer(d0, "t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
